// File: rtl/frame_cap_ctrl_pkg.sv
// Shared types and address constants for the frame capture controller.
package frame_cap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_VS   = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_WAIT_DONE = 2'd3
    } cap_state_e;

    localparam logic [31:0] BUF0_BASE_DEF    = 32'h1034_5688;
    localparam logic [31:0] FRAME_LENGTH_DEF = 32'h0012_C000;
    localparam logic [31:0] BUF1_BASE_DEF    = BUF0_BASE_DEF + FRAME_LENGTH_DEF;

    // Ping-pong buffer base: buffer 1 sits directly after buffer 0.
    function automatic logic [31:0] buf_base(input logic sel, input logic [31:0] b0,
                                             input logic [31:0] len);
        return sel ? (b0 + len) : b0;
    endfunction

endpackage

// File: rtl/frame_cap_ctrl_if.sv
// DMA command/status bundle between the capture controller and the write DMA.
interface frame_cap_ctrl_if;
    logic        dma_go;
    logic [31:0] dma_base;
    logic [31:0] dma_length;
    logic        dma_soft_reset;
    logic        dma_done;

    modport master (output dma_go, dma_base, dma_length, dma_soft_reset, input dma_done);
    modport slave  (input dma_go, dma_base, dma_length, dma_soft_reset, output dma_done);
endinterface

// File: rtl/frame_cap_ctrl_edge_det.sv
// Registered rising-edge detector for a level input.
module edge_det (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic d_i,
    output logic rise_o
);
    logic d_q;

    // Remember the previous sample of the level input.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) d_q <= 1'b0;
        else            d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/frame_cap_ctrl.sv
// Ping-pong frame capture sequencer: arms the DMA on each frame start,
// gates pixel strobes during the frame and tracks completions and overruns.
module frame_cap_ctrl
    import frame_cap_pkg::*;
#(
    parameter logic [31:0] BUF0_BASE    = BUF0_BASE_DEF,
    parameter logic [31:0] FRAME_LENGTH = FRAME_LENGTH_DEF,
    parameter int          CNT_W        = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start_req,
    input  logic [CNT_W-1:0]   frame_num,
    input  logic               abort,
    input  logic               cmos_vsync_begin,
    input  logic               cmos_vsync_end,
    input  logic               rgb_wr_en_in,
    output logic               wr_en_out,
    frame_cap_ctrl_if.master   dma,
    output logic               busy,
    output logic               status_done,
    output logic               frame_valid,
    output logic [31:0]        rd_base,
    output logic               wr_sel,
    output logic [CNT_W-1:0]   drop_cnt
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] frames_left_q, frames_left_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]      dma_base_q, dma_base_d;
    logic [31:0]      rd_base_q, rd_base_d;
    logic             dma_go_q, dma_go_d;
    logic             soft_rst_q, soft_rst_d;
    logic             wr_sel_q, wr_sel_d;
    logic             status_done_q, status_done_d;
    logic             frame_valid_q, frame_valid_d;
    logic             done_rise;

    edge_det u_done_edge (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .d_i       (dma.dma_done),
        .rise_o    (done_rise)
    );

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            frames_left_q <= '0;
            drop_cnt_q    <= '0;
            dma_base_q    <= BUF0_BASE;
            rd_base_q     <= BUF0_BASE;
            dma_go_q      <= 1'b0;
            soft_rst_q    <= 1'b0;
            wr_sel_q      <= 1'b0;
            status_done_q <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            frames_left_q <= frames_left_d;
            drop_cnt_q    <= drop_cnt_d;
            dma_base_q    <= dma_base_d;
            rd_base_q     <= rd_base_d;
            dma_go_q      <= dma_go_d;
            soft_rst_q    <= soft_rst_d;
            wr_sel_q      <= wr_sel_d;
            status_done_q <= status_done_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    // Next-state logic; abort from any active state overrides all other events.
    always_comb begin
        state_d       = state_q;
        frames_left_d = frames_left_q;
        drop_cnt_d    = drop_cnt_q;
        dma_base_d    = dma_base_q;
        rd_base_d     = rd_base_q;
        dma_go_d      = 1'b0;
        soft_rst_d    = 1'b0;
        wr_sel_d      = wr_sel_q;
        status_done_d = status_done_q;
        frame_valid_d = 1'b0;
        if (state_q != ST_IDLE && abort) begin
            state_d    = ST_IDLE;
            soft_rst_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: if (start_req) begin
                    frames_left_d = (frame_num == '0) ? ONE : frame_num;
                    status_done_d = 1'b0;
                    state_d       = ST_WAIT_VS;
                end
                ST_WAIT_VS: if (cmos_vsync_end) begin
                    dma_go_d   = 1'b1;
                    dma_base_d = buf_base(wr_sel_q, BUF0_BASE, FRAME_LENGTH);
                    state_d    = ST_CAPTURE;
                end
                ST_CAPTURE: if (cmos_vsync_begin) state_d = ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    // A new frame starting before completion is skipped and counted.
                    if (cmos_vsync_end && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + ONE;
                    if (done_rise) begin
                        rd_base_d     = dma_base_q;
                        wr_sel_d      = ~wr_sel_q;
                        frame_valid_d = 1'b1;
                        frames_left_d = frames_left_q - ONE;
                        if (frames_left_q == ONE) begin
                            status_done_d = 1'b1;
                            state_d       = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT_VS;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign wr_en_out          = rgb_wr_en_in & (state_q == ST_CAPTURE);
    assign busy               = (state_q != ST_IDLE);
    assign status_done        = status_done_q;
    assign frame_valid        = frame_valid_q;
    assign rd_base            = rd_base_q;
    assign wr_sel             = wr_sel_q;
    assign drop_cnt           = drop_cnt_q;
    assign dma.dma_go         = dma_go_q;
    assign dma.dma_base       = dma_base_q;
    assign dma.dma_length     = FRAME_LENGTH;
    assign dma.dma_soft_reset = soft_rst_q;
endmodule

// File: tb/tb_frame_cap_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_frame_cap_ctrl;
    localparam logic [31:0] B0  = 32'h1034_5688;
    localparam logic [31:0] B1  = 32'h1047_1688;
    localparam logic [31:0] LEN = 32'h0012_C000;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start_req = 1'b0, abort = 1'b0;
    logic [7:0] frame_num = 8'd1;
    logic       cmos_vsync_begin = 1'b0, cmos_vsync_end = 1'b0;
    logic       rgb_wr_en_in = 1'b0;
    logic       wr_en_out, busy, status_done, frame_valid, wr_sel;
    logic [31:0] rd_base;
    logic [7:0] drop_cnt;

    frame_cap_ctrl_if dma_if ();

    frame_cap_ctrl dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start_req(start_req),
        .frame_num(frame_num), .abort(abort), .cmos_vsync_begin(cmos_vsync_begin),
        .cmos_vsync_end(cmos_vsync_end), .rgb_wr_en_in(rgb_wr_en_in),
        .wr_en_out(wr_en_out), .dma(dma_if.master), .busy(busy),
        .status_done(status_done), .frame_valid(frame_valid), .rd_base(rd_base),
        .wr_sel(wr_sel), .drop_cnt(drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The capture job is described by what it is doing: nothing, waiting for a
    // frame to start, receiving a frame, or waiting for the DMA to finish.
    localparam int M_IDLE = 0, M_ARMED = 1, M_RECV = 2, M_FLUSH = 3;
    int          m_mode = M_IDLE;
    int          m_left = 0;
    int          m_drop = 0;
    bit          m_sel = 0, m_go = 0, m_sr = 0, m_fv = 0, m_done = 0, m_prev = 0;
    logic [31:0] m_base = B0, m_rd = B0;
    logic [31:0] bufs [2];
    bit          rise;

    initial begin
        bufs[0] = B0;
        bufs[1] = B1;
    end

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_mode = M_IDLE; m_left = 0; m_drop = 0; m_sel = 0; m_go = 0; m_sr = 0;
            m_fv = 0; m_done = 0; m_prev = 0; m_base = B0; m_rd = B0;
        end else begin
            rise   = dma_if.dma_done && !m_prev;
            m_prev = dma_if.dma_done;
            m_go = 0; m_fv = 0; m_sr = 0;
            if (m_mode != M_IDLE && abort) begin
                m_mode = M_IDLE;
                m_sr   = 1;
            end else if (m_mode == M_IDLE) begin
                if (start_req) begin
                    m_left = (frame_num == 0) ? 1 : int'(frame_num);
                    m_done = 0;
                    m_mode = M_ARMED;
                end
            end else if (m_mode == M_ARMED) begin
                if (cmos_vsync_end) begin
                    m_go = 1; m_base = bufs[m_sel]; m_mode = M_RECV;
                end
            end else if (m_mode == M_RECV) begin
                if (cmos_vsync_begin) m_mode = M_FLUSH;
            end else begin
                if (cmos_vsync_end && m_drop < 255) m_drop = m_drop + 1;
                if (rise) begin
                    m_rd = m_base; m_sel = !m_sel; m_fv = 1; m_left = m_left - 1;
                    if (m_left == 0) begin m_done = 1; m_mode = M_IDLE; end
                    else m_mode = M_ARMED;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge sys_clk) begin
        if (cmp_en) begin
            chk("dma_go",      {31'd0, dma_if.dma_go},         {31'd0, m_go});
            chk("dma_base",    dma_if.dma_base,                m_base);
            chk("dma_length",  dma_if.dma_length,              LEN);
            chk("soft_reset",  {31'd0, dma_if.dma_soft_reset}, {31'd0, m_sr});
            chk("wr_en_out",   {31'd0, wr_en_out},  {31'd0, rgb_wr_en_in && m_mode == M_RECV});
            chk("busy",        {31'd0, busy},        {31'd0, m_mode != M_IDLE});
            chk("status_done", {31'd0, status_done}, {31'd0, m_done});
            chk("frame_valid", {31'd0, frame_valid}, {31'd0, m_fv});
            chk("rd_base",     rd_base,              m_rd);
            chk("wr_sel",      {31'd0, wr_sel},      {31'd0, m_sel});
            chk("drop_cnt",    {24'd0, drop_cnt},    m_drop);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0; start_req = 0; abort = 0; cmos_vsync_begin = 0;
        cmos_vsync_end = 0; rgb_wr_en_in = 0; dma_if.dma_done = 0;
        tick(); tick();
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic start(input logic [7:0] n);
        frame_num = n; start_req = 1; tick(); start_req = 0;
    endtask

    task automatic pulse_ve();
        cmos_vsync_end = 1; tick(); cmos_vsync_end = 0;
    endtask

    task automatic pulse_vb();
        cmos_vsync_begin = 1; tick(); cmos_vsync_begin = 0;
    endtask

    logic [31:0] exp_seq [3];

    initial begin
        dma_if.dma_done = 1'b0;
        exp_seq[0] = 32'h1034_5688; exp_seq[1] = 32'h1047_1688; exp_seq[2] = 32'h1034_5688;
        do_reset();
        cmp_en = 1'b1;

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dma_base", dma_if.dma_base, 32'h1034_5688);
        chk("rst_rd_base", rd_base, 32'h1034_5688);

        // Single frame
        start(8'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        rgb_wr_en_in = 1; #1;
        chk("t1_wr_en_waitvs", {31'd0, wr_en_out}, 32'd0);
        #1 pulse_ve();
        chk("t1_go", {31'd0, dma_if.dma_go}, 32'd1);
        chk("t1_base", dma_if.dma_base, 32'h1034_5688);
        chk("t1_wr_en_cap", {31'd0, wr_en_out}, 32'd1);
        rgb_wr_en_in = 0; #1;
        chk("t1_wr_en_follow", {31'd0, wr_en_out}, 32'd0);
        rgb_wr_en_in = 1; tick();
        chk("t1_go_once", {31'd0, dma_if.dma_go}, 32'd0);
        pulse_vb();
        chk("t1_wr_en_after", {31'd0, wr_en_out}, 32'd0);
        rgb_wr_en_in = 0;
        dma_if.dma_done = 1; tick();
        chk("t1_fv", {31'd0, frame_valid}, 32'd1);
        chk("t1_rd_base", rd_base, 32'h1034_5688);
        chk("t1_wr_sel", {31'd0, wr_sel}, 32'd1);
        chk("t1_done", {31'd0, status_done}, 32'd1);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        dma_if.dma_done = 0; tick();
        chk("t1_fv_pulse", {31'd0, frame_valid}, 32'd0);

        // Three frames, ping-pong bases
        do_reset();
        start(8'd3);
        for (int f = 0; f < 3; f++) begin
            pulse_ve();
            chk("t2_base", dma_if.dma_base, exp_seq[f]);
            pulse_vb();
            chk("t2_done_early", {31'd0, status_done}, 32'd0);
            dma_if.dma_done = 1; tick();
            chk("t2_fv", {31'd0, frame_valid}, 32'd1);
            chk("t2_done", {31'd0, status_done}, (f == 2) ? 32'd1 : 32'd0);
            dma_if.dma_done = 0; tick();
        end

        // Overrun drop, then saturation
        do_reset();
        start(8'd1);
        pulse_ve(); pulse_vb(); pulse_ve();
        chk("t3_drop", {24'd0, drop_cnt}, 32'd1);
        chk("t3_no_go", {31'd0, dma_if.dma_go}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 300; i++) pulse_ve();
        chk("t3_drop_sat", {24'd0, drop_cnt}, 32'h0000_00FF);
        dma_if.dma_done = 1; tick();
        chk("t3_fv", {31'd0, frame_valid}, 32'd1);
        chk("t3_status", {31'd0, status_done}, 32'd1);
        dma_if.dma_done = 0; tick();

        // Abort during capture
        do_reset();
        start(8'd2);
        pulse_ve();
        rgb_wr_en_in = 1; #1;
        chk("t4_wr_en", {31'd0, wr_en_out}, 32'd1);
        abort = 1; #1 tick(); abort = 0;
        chk("t4_wr_en_off", {31'd0, wr_en_out}, 32'd0);
        chk("t4_soft_reset", {31'd0, dma_if.dma_soft_reset}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_status", {31'd0, status_done}, 32'd0);
        chk("t4_wr_sel", {31'd0, wr_sel}, 32'd0);
        rgb_wr_en_in = 0; tick();
        chk("t4_sr_pulse", {31'd0, dma_if.dma_soft_reset}, 32'd0);

        // frame_num = 0 and start while busy
        do_reset();
        start(8'd0);
        pulse_ve();
        start(8'd5);
        pulse_vb();
        dma_if.dma_done = 1; tick();
        chk("t5_status", {31'd0, status_done}, 32'd1);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        dma_if.dma_done = 0; tick();

        // Asynchronous reset while waiting for completion
        do_reset();
        start(8'd2);
        pulse_ve(); pulse_vb();
        dma_if.dma_done = 1; tick(); dma_if.dma_done = 0;
        pulse_ve(); pulse_vb();
        chk("t6_pre_sel", {31'd0, wr_sel}, 32'd1);
        chk("t6_pre_base", dma_if.dma_base, 32'h1047_1688);
        rgb_wr_en_in = 1;
        sys_rst_n = 0; #1;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_wr_en", {31'd0, wr_en_out}, 32'd0);
        chk("t6_wr_sel", {31'd0, wr_sel}, 32'd0);
        chk("t6_dma_base", dma_if.dma_base, 32'h1034_5688);
        chk("t6_rd_base", rd_base, 32'h1034_5688);
        #1 sys_rst_n = 1; rgb_wr_en_in = 0;
        dma_if.dma_done = 1; tick();
        chk("t6_no_fv", {31'd0, frame_valid}, 32'd0);
        chk("t6_still_idle", {31'd0, busy}, 32'd0);
        dma_if.dma_done = 0; tick();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                abort = 1; start_req = 0; cmos_vsync_end = 0; cmos_vsync_begin = 0;
            end else begin
                abort            = 0;
                start_req        = ($urandom_range(0, 9) == 0);
                cmos_vsync_end   = ($urandom_range(0, 7) == 0);
                cmos_vsync_begin = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 4) == 0) dma_if.dma_done = ~dma_if.dma_done;
            end
            rgb_wr_en_in = $urandom_range(0, 1) == 1;
            frame_num    = 8'($urandom_range(0, 3));
            tick();
        end
        abort = 0; start_req = 0; cmos_vsync_end = 0; cmos_vsync_begin = 0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
